// File: rtl/cdm_pkg.sv
`default_nettype none
// cdm_pkg: mode encodings and FSM state type shared by the carry-disregard multiplier family.
package cdm_pkg;

  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_CDA   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cdm_row_step.sv
`default_nettype none
// cdm_row_step: one shift-and-accumulate row; adds (exact) or XORs (carry-disregard) a
// shifted, gated copy of the multiplicand into the accumulator.
module cdm_row_step #(
  parameter int WA = 8,
  parameter int WB = 4,
  localparam int CW = $clog2(WB) + 1
) (
  input  logic [WA+WB-1:0] acc,
  input  logic [WA-1:0]    a,
  input  logic             b_bit,
  input  logic [CW-1:0]    shift,
  input  logic             mode,
  output logic [WA+WB-1:0] acc_next
);
  import cdm_pkg::*;

  logic [WA+WB-1:0] pp;

  assign pp       = ({{WB{1'b0}}, a} & {(WA+WB){b_bit}}) << shift;
  // The accumulator is as wide as the full product, so the exact sum never overflows.
  assign acc_next = (mode == MODE_CDA) ? (acc ^ pp) : (acc + pp);

endmodule
`default_nettype wire

// File: rtl/cdm_seq_mult.sv
`default_nettype none
// cdm_seq_mult: iterative WA x WB multiplier, one multiplier bit per cycle, exact or
// carry-less (GF(2)) product selected per operation, valid/ready on both sides.
module cdm_seq_mult #(
  parameter int WA = 8,
  parameter int WB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WA-1:0]    in_a,
  input  logic [WB-1:0]    in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WA+WB-1:0] out_r,
  output logic             out_mode
);
  import cdm_pkg::*;

  localparam int            CW   = $clog2(WB) + 1;
  localparam logic [CW-1:0] LAST = CW'(WB - 1);

  state_t           state;
  logic [WA-1:0]    a_q;
  logic [WB-1:0]    b_q;
  logic             mode_q;
  logic [WA+WB-1:0] acc;
  logic [WA+WB-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic             cur_bit;

  assign cur_bit = |(b_q & (WB'(1) << cnt));

  cdm_row_step #(
    .WA(WA),
    .WB(WB)
  ) u_row_step (
    .acc      (acc),
    .a        (a_q),
    .b_bit    (cur_bit),
    .shift    (cnt),
    .mode     (mode_q),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_mode  <= MODE_EXACT;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= MODE_EXACT;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_q      <= in_a;
            b_q      <= in_b;
            mode_q   <= in_mode;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          // Zero operands still take all WB rows so latency is data-independent.
          if (cnt == LAST) begin
            out_valid <= 1'b1;
            out_r     <= acc_next;
            out_mode  <= mode_q;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdm_seq_mult.sv
`default_nettype none
// tb_cdm_seq_mult: directed 8x4 vectors and corner sequences, then randomized 16x8
// traffic with handshake gaps checked against an arithmetic reference model.
module tb_cdm_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
  logic [7:0]  in_a;
  logic [3:0]  in_b;
  logic [11:0] out_r;

  logic        in_valid2, in_ready2, in_mode2, out_valid2, out_ready2, out_mode2;
  logic [15:0] in_a2;
  logic [7:0]  in_b2;
  logic [23:0] out_r2;

  cdm_seq_mult #(.WA(8), .WB(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_mode(out_mode)
  );

  cdm_seq_mult #(.WA(16), .WB(8)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2), .in_mode(in_mode2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_r(out_r2), .out_mode(out_mode2)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0]  a;
    logic [3:0]  b;
    logic        mode;
    logic [11:0] exp_r;
  } vec_t;

  typedef struct {
    logic        mode;
    logic [23:0] r;
  } exp_t;

  vec_t vecs[8];
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Exact product by integer multiply; carry-less product as a GF(2) polynomial convolution.
  function automatic logic [23:0] ref_model(input logic [15:0] a, input logic [7:0] b, input logic m);
    logic [23:0] r;
    r = '0;
    if (!m) r = 24'(a) * 24'(b);
    else
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 8; j++)
          r[i+j] = r[i+j] ^ (a[i] & b[j]);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge where out_valid is first seen (or timeout).
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input logic m,
                        input bit toggle, output int lat);
    int k;
    in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (toggle) in_mode = ~in_mode;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit, got t=%0t expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int w;

    vecs[0] = '{8'hFF, 4'hF, 1'b0, 12'hEF1};
    vecs[1] = '{8'hFF, 4'hF, 1'b1, 12'h505};
    vecs[2] = '{8'h03, 4'h3, 1'b0, 12'h009};
    vecs[3] = '{8'h03, 4'h3, 1'b1, 12'h005};
    vecs[4] = '{8'h00, 4'hF, 1'b0, 12'h000};
    vecs[5] = '{8'h00, 4'hF, 1'b1, 12'h000};
    vecs[6] = '{8'hA5, 4'h9, 1'b0, 12'h5CD};
    vecs[7] = '{8'hA5, 4'h9, 1'b1, 12'h58D};

    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0; in_mode2 = 1'b0; out_ready2 = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_in_ready",  64'(in_ready),  64'(0));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_r",     64'(out_r),     64'(0));
    check("reset_out_mode",  64'(out_mode),  64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready), 64'(1));

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].mode, 1'b0, lat);
      check($sformatf("vec%0d_r", i),    64'(out_r),    64'(vecs[i].exp_r));
      check($sformatf("vec%0d_mode", i), 64'(out_mode), 64'(vecs[i].mode));
      check($sformatf("vec%0d_lat", i),  64'(lat),      64'(4));
      if (vecs[i].mode) check($sformatf("vec%0d_msb", i), 64'(out_r[11]), 64'(0));
      drain();
      check($sformatf("vec%0d_drained", i), 64'(out_valid), 64'(0));
    end

    // Backpressure: result held in DONE while a new request waits.
    run_op(8'hA5, 4'h9, 1'b0, 1'b0, lat);
    in_a = 8'h3C; in_b = 4'h6; in_mode = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_out_r",     64'(out_r),     64'(12'h5CD));
      check("bp_out_mode",  64'(out_mode),  64'(0));
      check("bp_in_ready",  64'(in_ready),  64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_valid_dropped", 64'(out_valid), 64'(0));
    check("bp_ready_after_hs", 64'(in_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_new_accepted", 64'(in_ready), 64'(0));
    w = 0;
    while (!out_valid && w < 50) begin @(negedge clk); w++; end
    check("bp_new_r",    64'(out_r),    64'(12'h088));
    check("bp_new_mode", 64'(out_mode), 64'(1));
    drain();

    // Mode isolation: in_mode toggles every cycle during BUSY.
    run_op(8'hFF, 4'hF, 1'b1, 1'b1, lat);
    check("iso_r",    64'(out_r),    64'(12'h505));
    check("iso_mode", 64'(out_mode), 64'(1));
    in_mode = 1'b0;
    drain();

    // Asynchronous reset in the middle of BUSY abandons the operation.
    in_a = 8'hFF; in_b = 4'hF; in_mode = 1'b0; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_no_result", 64'(out_valid), 64'(0));
    run_op(8'h12, 4'h5, 1'b0, 1'b0, lat);
    check("rst_fresh_r",   64'(out_r), 64'(12'h05A));
    check("rst_fresh_lat", 64'(lat),   64'(4));
    drain();

    // Randomized 16x8 traffic with gaps on both sides.
    fork
      begin : producer
        logic [15:0] a;
        logic [7:0]  b;
        logic        m;
        int          gw;
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = 16'($urandom); b = 8'($urandom); m = 1'($urandom);
          in_a2 = a; in_b2 = b; in_mode2 = m; in_valid2 = 1'b1;
          gw = 0;
          while (!in_ready2 && gw < 100) begin @(negedge clk); gw++; end
          if (!in_ready2) begin
            check("rand_accept_timeout", 64'(in_ready2), 64'(1));
            in_valid2 = 1'b0;
            break;
          end
          exp_q.push_back('{m, ref_model(a, b, m)});
          @(posedge clk);
          @(negedge clk);
          in_valid2 = 1'b0;
          in_mode2  = ~in_mode2;
        end
      end
      begin : consumer
        exp_t e;
        int   got;
        int   cyc;
        got = 0;
        cyc = 0;
        while (got < 1000 && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          out_ready2 = ($urandom_range(0, 3) != 0);
          if (out_valid2 && out_ready2) begin
            if (exp_q.size() == 0) begin
              check("rand_unexpected_result", 64'(out_r2), 64'(0));
            end else begin
              e = exp_q.pop_front();
              check("rand_r",    64'(out_r2),    64'(e.r));
              check("rand_mode", 64'(out_mode2), 64'(e.mode));
            end
            got++;
          end
        end
        out_ready2 = 1'b0;
        check("rand_result_count", 64'(got), 64'(1000));
      end
    join
    check("rand_leftover", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
